// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester, UART-TX and status signals around the TX arbiter.
// The master modport is the arbiter's view; slave is the surrounding system's view.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_accept;
    logic                 tx_dv;
    logic [7:0]           tx_data;
    logic                 tx_done;
    logic                 busy;
    logic [ID_W-1:0]      grant_id;
    logic [15:0]          sent_count;
    logic                 timeout_err;
    logic                 err_clr;

    modport master (
        input  req_valid,
        input  req_data,
        input  tx_done,
        input  err_clr,
        output req_accept,
        output tx_dv,
        output tx_data,
        output busy,
        output grant_id,
        output sent_count,
        output timeout_err
    );

    modport slave (
        output req_valid,
        output req_data,
        output tx_done,
        output err_clr,
        input  req_accept,
        input  tx_dv,
        input  tx_data,
        input  busy,
        input  grant_id,
        input  sent_count,
        input  timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters,
// with a done/timeout wait per byte and simple status outputs.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TMR_W          = 17
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    localparam logic [ID_W:0]    NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

    // Fold a sum of two indices (each < NUM_REQ) back into 0..NUM_REQ-1.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W:0] sum);
        logic [ID_W:0] r;
        if (sum >= NUM_REQ_W) begin
            r = sum - NUM_REQ_W;
        end else begin
            r = sum;
        end
        return r[ID_W-1:0];
    endfunction

    // Returns {found, index}; scanning offsets high-to-low lets the lowest offset win.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr);
        logic [ID_W:0]   result;
        logic [ID_W-1:0] idx;
        result = {(ID_W+1){1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = wrap_idx({1'b0, ptr} + (ID_W+1)'(k));
            if (valid[idx]) begin
                result = {1'b1, idx};
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    state_e               state_q,       state_d;
    logic [ID_W-1:0]      rr_ptr_q,      rr_ptr_d;
    logic                 tx_dv_q,       tx_dv_d;
    logic [7:0]           tx_data_q,     tx_data_d;
    logic [NUM_REQ-1:0]   req_accept_q,  req_accept_d;
    logic [ID_W-1:0]      grant_id_q,    grant_id_d;
    logic [15:0]          sent_count_q,  sent_count_d;
    logic                 timeout_err_q, timeout_err_d;
    logic [TMR_W-1:0]     timer_q,       timer_d;

    logic [ID_W:0]        pick_s;
    logic                 pick_found_s;
    logic [ID_W-1:0]      pick_idx_s;
    logic                 timeout_hit_s;

    assign pick_s       = rr_pick(bus.req_valid, rr_ptr_q);
    assign pick_found_s = pick_s[ID_W];
    assign pick_idx_s   = pick_s[ID_W-1:0];

    // Next-state and registered-output computation for the grant FSM.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        tx_dv_d       = 1'b0;
        tx_data_d     = tx_data_q;
        req_accept_d  = {NUM_REQ{1'b0}};
        grant_id_d    = grant_id_q;
        sent_count_d  = sent_count_q;
        timer_d       = timer_q;
        timeout_hit_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    tx_data_d    = bus.req_data[{pick_idx_s, 3'b000} +: 8];
                    grant_id_d   = pick_idx_s;
                    req_accept_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
                    tx_dv_d      = 1'b1;
                    rr_ptr_d     = wrap_idx({1'b0, pick_idx_s} + {{ID_W{1'b0}}, 1'b1});
                    state_d      = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                timer_d = {TMR_W{1'b0}};
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Done takes priority over a timeout landing on the same edge.
                if (bus.tx_done) begin
                    sent_count_d = sent_count_q + 16'd1;
                    state_d      = ST_IDLE;
                end else if (timer_q == TMR_LAST) begin
                    timeout_hit_s = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    timer_d = timer_q + {{(TMR_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A timeout on the same edge as err_clr leaves the flag set.
        if (timeout_hit_s) begin
            timeout_err_d = 1'b1;
        end else if (bus.err_clr) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end
    end

    // State and output registers; reset abandons any byte in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= {ID_W{1'b0}};
            tx_dv_q       <= 1'b0;
            tx_data_q     <= 8'h00;
            req_accept_q  <= {NUM_REQ{1'b0}};
            grant_id_q    <= {ID_W{1'b0}};
            sent_count_q  <= 16'h0000;
            timeout_err_q <= 1'b0;
            timer_q       <= {TMR_W{1'b0}};
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            tx_dv_q       <= tx_dv_d;
            tx_data_q     <= tx_data_d;
            req_accept_q  <= req_accept_d;
            grant_id_q    <= grant_id_d;
            sent_count_q  <= sent_count_d;
            timeout_err_q <= timeout_err_d;
            timer_q       <= timer_d;
        end
    end

    assign bus.req_accept  = req_accept_q;
    assign bus.tx_dv       = tx_dv_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.sent_count  = sent_count_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random
// transactions, all checked against a transaction-level reference model.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TO      = 20;
    localparam int TMR_W   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W(ID_W),
        .TIMEOUT_CYCLES(TO),
        .TMR_W(TMR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int              m_ptr  = 0;
    logic [15:0]     m_sent = 16'h0000;
    logic            m_err  = 1'b0;
    logic [7:0]      m_data = 8'h00;
    logic [ID_W-1:0] m_gid  = '0;

    function automatic int model_pick(input logic [NUM_REQ-1:0] v);
        for (int off = 0; off < NUM_REQ; off++) begin
            if (v[(m_ptr + off) % NUM_REQ]) return (m_ptr + off) % NUM_REQ;
        end
        return -1;
    endfunction

    // One grant: request v/d, tx_done sampled j edges after the grant edge (0 = never),
    // err_clr sampled clr_at edges after the grant edge (0 = never).
    task automatic run_txn(input logic [NUM_REQ-1:0] v, input logic [8*NUM_REQ-1:0] d,
                           input int j, input int clr_at);
        int sel, end_off, last;
        bit counted;
        logic [NUM_REQ-1:0] exp_acc;
        sel = model_pick(v);
        bus.req_valid = v;
        bus.req_data  = d;
        @(posedge clk); #1;
        bus.req_valid = '0;
        exp_acc = NUM_REQ'(1) << sel;
        m_data  = d[8*sel +: 8];
        m_gid   = ID_W'(sel);
        m_ptr   = (sel + 1) % NUM_REQ;
        n_cmp++;
        if (bus.tx_dv !== 1'b1 || bus.req_accept !== exp_acc || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL load_handshake: dv=%b accept=%b busy=%b, expected 1 %b 1",
                     bus.tx_dv, bus.req_accept, bus.busy, exp_acc);
        end
        n_cmp++;
        if (bus.tx_data !== m_data || bus.grant_id !== m_gid) begin
            n_err++;
            $display("FAIL load_data: data=%h gid=%0d, expected %h %0d",
                     bus.tx_data, bus.grant_id, m_data, m_gid);
        end
        counted = (j >= 2 && j <= TO + 1);
        end_off = counted ? j : TO + 1;
        last    = (j > end_off) ? j : end_off;
        if (clr_at > last) last = clr_at;
        for (int c = 1; c <= last; c++) begin
            bus.tx_done = (c == j);
            bus.err_clr = (c == clr_at);
            @(posedge clk); #1;
            bus.tx_done = 1'b0;
            bus.err_clr = 1'b0;
            if (c == end_off && counted) m_sent = m_sent + 16'd1;
            if (c == end_off && !counted) m_err = 1'b1;
            else if (c == clr_at) m_err = 1'b0;
            n_cmp++;
            if (bus.busy !== (c < end_off) || bus.tx_dv !== 1'b0 || bus.req_accept !== '0) begin
                n_err++;
                $display("FAIL wait_ctrl c=%0d: busy=%b dv=%b accept=%b, expected %b 0 0",
                         c, bus.busy, bus.tx_dv, bus.req_accept, (c < end_off));
            end
            n_cmp++;
            if (bus.sent_count !== m_sent || bus.timeout_err !== m_err) begin
                n_err++;
                $display("FAIL wait_status c=%0d: count=%0d err=%b, expected %0d %b",
                         c, bus.sent_count, bus.timeout_err, m_sent, m_err);
            end
            n_cmp++;
            if (bus.tx_data !== m_data || bus.grant_id !== m_gid) begin
                n_err++;
                $display("FAIL hold c=%0d: data=%h gid=%0d, expected %h %0d",
                         c, bus.tx_data, bus.grant_id, m_data, m_gid);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_cmp++;
        if (bus.tx_dv !== 1'b0 || bus.req_accept !== '0 || bus.tx_data !== 8'h00 ||
            bus.grant_id !== '0 || bus.sent_count !== 16'h0000 ||
            bus.timeout_err !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s: dv=%b acc=%b data=%h gid=%0d cnt=%0d err=%b busy=%b, expected all 0",
                     tag, bus.tx_dv, bus.req_accept, bus.tx_data, bus.grant_id,
                     bus.sent_count, bus.timeout_err, bus.busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_held");
        rst = 1'b0;
        @(posedge clk); #1;
        check_all_zero("reset_released");
    endtask

    task automatic test_back_to_back();
        int sel;
        bus.req_valid = 4'hF;
        bus.req_data  = 32'h13121110;
        @(posedge clk); #1;
        for (int g = 0; g < 6; g++) begin
            sel     = model_pick(4'hF);
            m_data  = 8'h10 + 8'(sel);
            m_gid   = ID_W'(sel);
            m_ptr   = (sel + 1) % NUM_REQ;
            n_cmp++;
            if (bus.tx_dv !== 1'b1 || bus.grant_id !== m_gid || bus.tx_data !== m_data ||
                bus.req_accept !== (NUM_REQ'(1) << sel)) begin
                n_err++;
                $display("FAIL b2b_grant g=%0d: dv=%b gid=%0d data=%h acc=%b, expected 1 %0d %h",
                         g, bus.tx_dv, bus.grant_id, bus.tx_data, bus.req_accept, m_gid, m_data);
            end
            if (g == 5) bus.req_valid = '0;
            for (int c = 1; c <= 6; c++) begin
                bus.tx_done = (c == 5);
                @(posedge clk); #1;
                bus.tx_done = 1'b0;
                if (c == 5) m_sent = m_sent + 16'd1;
                if (c < 6 || g == 5) begin
                    n_cmp++;
                    if (bus.tx_dv !== 1'b0 || bus.busy !== (c < 5)) begin
                        n_err++;
                        $display("FAIL b2b_gap g=%0d c=%0d: dv=%b busy=%b, expected 0 %b",
                                 g, c, bus.tx_dv, bus.busy, (c < 5));
                    end
                end
            end
        end
        n_cmp++;
        if (bus.sent_count !== m_sent) begin
            n_err++;
            $display("FAIL b2b_count: %0d, expected %0d", bus.sent_count, m_sent);
        end
    endtask

    task automatic test_single();
        run_txn(4'b0001, {24'h0, 8'hA5}, 10, 0);
    endtask

    task automatic test_rr_wrap();
        run_txn(4'b1000, 32'h44332211, 3, 0);
        run_txn(4'b0101, 32'h55667788, 4, 0);
        run_txn(4'b0101, 32'h99AABBCC, 2, 0);
    endtask

    task automatic test_timeout();
        run_txn(4'b0010, 32'hDEADBEEF, 0, 0);
        run_txn(4'b0100, 32'h01234567, 3, 0);
        bus.err_clr = 1'b1;
        @(posedge clk); #1;
        bus.err_clr = 1'b0;
        m_err = 1'b0;
        n_cmp++;
        if (bus.timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL err_clr: timeout_err=%b, expected 0", bus.timeout_err);
        end
        run_txn(4'b1001, 32'h0F1E2D3C, 0, TO + 1);
        run_txn(4'b0110, 32'h5A5A5A5A, 6, 2);
    endtask

    task automatic test_exact_timeout();
        run_txn(4'b1111, 32'hCAFEF00D, TO + 1, 1);
        run_txn(4'b0011, 32'h87654321, 1, 0);
    endtask

    task automatic test_idle_done();
        bus.tx_done = 1'b1;
        @(posedge clk); #1;
        bus.tx_done = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.sent_count !== m_sent || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_done: count=%0d busy=%b, expected %0d 0",
                     bus.sent_count, bus.busy, m_sent);
        end
    endtask

    task automatic test_reset_mid();
        bus.req_valid = 4'b0100;
        bus.req_data  = 32'h00770000;
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("reset_async");
        m_ptr = 0; m_sent = 16'h0000; m_err = 1'b0; m_data = 8'h00; m_gid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.tx_done = 1'b1;
        @(posedge clk); #1;
        bus.tx_done = 1'b0;
        @(posedge clk); #1;
        check_all_zero("late_done");
        run_txn(4'b1111, 32'h0D0C0B0A, 3, 0);
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] v;
        int j, clr;
        for (int t = 0; t < 30; t++) begin
            v   = NUM_REQ'($urandom_range(1, 15));
            j   = $urandom_range(0, TO + 4);
            clr = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TO + 1) : 0;
            run_txn(v, $urandom, j, clr);
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_done   = 1'b0;
        bus.err_clr   = 1'b0;
        test_reset();
        test_back_to_back();
        test_single();
        test_rr_wrap();
        test_timeout();
        test_exact_timeout();
        test_idle_done();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
